// File: rtl/ltc2308_pkg.sv
// ltc2308_pkg
//   Shared types and constants for the LTC2308 conversion engine.
//   - state_e      : engine FSM states (IDLE/CONV/SHIFT/ACQ)
//   - CFG_*        : bit positions inside the optional cfg_i[1:0] = {diff, bipolar}
//   - WORD_W       : width of the ADC configuration word (6)
//   - DATA_W       : conversion result width (12)
//   - SCK_PERIODS  : SCK periods per SPI frame (12)
//   - build_word() : assembles {S/D, O/S, S1, S0, UNI, SLP} from channel and mode
package ltc2308_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        ACQ   = 2'd3
    } state_e;

    localparam int CFG_BIP  = 0;
    localparam int CFG_DIFF = 1;

    localparam int WORD_W      = 6;
    localparam int DATA_W      = 12;
    localparam int SCK_PERIODS = 12;

    // The ADC's channel select is odd/sign in bit O/S and the upper two
    // channel bits in S1:S0, hence the ch[0], ch[2], ch[1] ordering.
    function automatic logic [WORD_W-1:0] build_word(input logic [2:0] ch,
                                                     input logic       diff,
                                                     input logic       bip);
        return {~diff, ch[0], ch[2], ch[1], ~bip, 1'b0};
    endfunction

endpackage

// File: rtl/ltc2308_sck_gen.sv
// ltc2308_sck_gen
//   SPI clock generator for one 12-period LTC2308 frame. While en_i is high it
//   toggles SCK every SCK_HALF clocks, starting low, and flags the clock edges
//   at which SCK is about to rise or fall. Dropping en_i returns it to idle.
//   Ports:
//     clock, reset_n : engine clock, asynchronous active-low reset
//     en_i           : run the frame (high for the whole SHIFT state)
//     sck_o          : registered SCK, idles low
//     rise_o/fall_o  : SCK goes high/low at the next clock edge
//     last_fall_o    : the falling edge that ends the 12th period
module ltc2308_sck_gen
    import ltc2308_pkg::*;
#(
    parameter int SCK_HALF = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o,
    output logic last_fall_o
);

    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int PW = $clog2(SCK_PERIODS + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(SCK_PERIODS - 1);

    logic [HW-1:0] half_q, half_d;
    logic [PW-1:0] per_q, per_d;
    logic          sck_q, sck_d;
    logic          half_end;

    assign half_end    = (half_q == HALF_LAST);
    assign rise_o      = en_i & half_end & ~sck_q;
    assign fall_o      = en_i & half_end & sck_q;
    assign last_fall_o = fall_o & (per_q == PER_LAST);
    assign sck_o       = sck_q;

    always_comb begin
        half_d = half_q;
        per_d  = per_q;
        sck_d  = sck_q;
        if (!en_i) begin
            half_d = '0;
            per_d  = '0;
            sck_d  = 1'b0;
        end else if (half_end) begin
            half_d = '0;
            sck_d  = ~sck_q;
            // a period completes on its falling edge
            if (sck_q) per_d = per_q + PW'(1);
        end else begin
            half_d = half_q + HW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            half_q <= '0;
            per_q  <= '0;
            sck_q  <= 1'b0;
        end else begin
            half_q <= half_d;
            per_q  <= per_d;
            sck_q  <= sck_d;
        end
    end

endmodule

// File: rtl/ltc2308_conv_engine.sv
// ltc2308_conv_engine
//   Runs one LTC2308 conversion per accepted start: CONVST pulse for
//   TCONV_CYCLES, a 12-period SPI frame (config word out on SDI, previous
//   result in on SDO), then TACQ_CYCLES of acquisition time before done_o.
//   Optional feature macro: LTC2308_DIFF_MODE_EN adds cfg_i[1:0] = {diff, bipolar}.
//   Ports:
//     clock, reset_n        : engine clock, asynchronous active-low reset
//     start_i, ch_i[2:0]    : request and channel, accepted while busy_o=0
//     cfg_i[1:0]            : (LTC2308_DIFF_MODE_EN only) mode, sampled with start_i
//     busy_o, done_o        : frame in progress / 1-cycle result strobe
//     data_o[11:0]          : result of this frame, held until next done_o
//     data_ch_o[2:0]        : channel that produced data_o
//     data_stale_o          : data_o comes from the first frame after reset
//     ADC_CONVST_o, ADC_SCK_o, ADC_SDI_o, ADC_SDO_i : ADC pins
module ltc2308_conv_engine
    import ltc2308_pkg::*;
#(
    parameter int TCONV_CYCLES = 64,
    parameter int TACQ_CYCLES  = 10,
    parameter int SCK_HALF     = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [2:0]        ch_i,
`ifdef LTC2308_DIFF_MODE_EN
    input  logic [1:0]        cfg_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] data_o,
    output logic [2:0]        data_ch_o,
    output logic              data_stale_o,
    output logic              ADC_CONVST_o,
    output logic              ADC_SCK_o,
    output logic              ADC_SDI_o,
    input  logic              ADC_SDO_i
);

    localparam int CNT_MAX = (TCONV_CYCLES > TACQ_CYCLES) ? TCONV_CYCLES : TACQ_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(TCONV_CYCLES - 1);
    localparam logic [CW-1:0] ACQ_LAST  = CW'(TACQ_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                convst_q, convst_d;
    logic                sdi_q, sdi_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [2:0]          ch_q, ch_d;
    logic [2:0]          prev_ch_q, prev_ch_d;
    logic                stale_q, stale_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [2:0]          data_ch_q, data_ch_d;
    logic                data_stale_q, data_stale_d;
    logic [WORD_W-1:0]   start_word;
    logic                sck_rise, sck_fall, sck_last_fall;

`ifdef LTC2308_DIFF_MODE_EN
    assign start_word = build_word(ch_i, cfg_i[CFG_DIFF], cfg_i[CFG_BIP]);
`else
    assign start_word = build_word(ch_i, 1'b0, 1'b0);
`endif

    ltc2308_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .clock       (clock),
        .reset_n     (reset_n),
        .en_i        (state_q == SHIFT),
        .sck_o       (ADC_SCK_o),
        .rise_o      (sck_rise),
        .fall_o      (sck_fall),
        .last_fall_o (sck_last_fall)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        convst_d     = convst_q;
        sdi_d        = sdi_q;
        word_d       = word_q;
        shift_d      = shift_q;
        ch_d         = ch_q;
        prev_ch_d    = prev_ch_q;
        stale_d      = stale_q;
        data_d       = data_q;
        data_ch_d    = data_ch_q;
        data_stale_d = data_stale_q;

        // busy stays up through the done cycle so a start there is ignored
        if (done_q) busy_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i && !busy_q) begin
                    ch_d     = ch_i;
                    word_d   = start_word;
                    convst_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = CONV;
                end
            end
            CONV: begin
                if (cnt_q == CONV_LAST) begin
                    convst_d = 1'b0;
                    sdi_d    = word_q[WORD_W-1];
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (sck_rise) shift_d = {shift_q[DATA_W-2:0], ADC_SDO_i};
                if (sck_fall) begin
                    // word_q drains to zeros, so SDI is 0 after the 6th bit
                    word_d = {word_q[WORD_W-2:0], 1'b0};
                    sdi_d  = word_q[WORD_W-2];
                end
                if (sck_last_fall) begin
                    sdi_d        = 1'b0;
                    data_d       = shift_q;
                    data_ch_d    = prev_ch_q;
                    data_stale_d = stale_q;
                    prev_ch_d    = ch_q;
                    stale_d      = 1'b0;
                    cnt_d        = '0;
                    state_d      = ACQ;
                end
            end
            ACQ: begin
                if (cnt_q == ACQ_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            convst_q     <= 1'b0;
            sdi_q        <= 1'b0;
            word_q       <= '0;
            shift_q      <= '0;
            ch_q         <= '0;
            prev_ch_q    <= '0;
            stale_q      <= 1'b1;
            data_q       <= '0;
            data_ch_q    <= '0;
            data_stale_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            convst_q     <= convst_d;
            sdi_q        <= sdi_d;
            word_q       <= word_d;
            shift_q      <= shift_d;
            ch_q         <= ch_d;
            prev_ch_q    <= prev_ch_d;
            stale_q      <= stale_d;
            data_q       <= data_d;
            data_ch_q    <= data_ch_d;
            data_stale_q <= data_stale_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign data_o       = data_q;
    assign data_ch_o    = data_ch_q;
    assign data_stale_o = data_stale_q;
    assign ADC_CONVST_o = convst_q;
    assign ADC_SDI_o    = sdi_q;

endmodule

// File: tb/tb_ltc2308_conv_engine.sv
// tb_ltc2308_conv_engine
//   Two engines share clock/reset: [0] default timing, [1] TCONV=8, TACQ=4,
//   SCK_HALF=3. Each has a pin-level ADC model that serves a chosen 12-bit
//   value MSB first (next bit after every SCK fall) and records SDI on SCK rises.
//   With LTC2308_DIFF_MODE_EN the cfg_i ports are connected and a diff frame runs.
module tb_ltc2308_conv_engine;

    localparam int T1C = 8;
    localparam int T1A = 4;
    localparam int H1  = 3;
    localparam int LAT[2]  = '{1 + 64 + 24 * 1 + 10, 1 + T1C + 24 * H1 + T1A};
    localparam int HALF[2] = '{1, H1};

    logic        clock;
    logic        reset_n;
    logic        start[2];
    logic [2:0]  ch[2];
`ifdef LTC2308_DIFF_MODE_EN
    logic [1:0]  cfg[2];
`endif
    logic        busy[2], done[2], stale[2], convst[2], sck[2], sdi[2], sdo[2];
    logic [11:0] data[2];
    logic [2:0]  dch[2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // ADC / monitor state, owned by the per-instance monitor blocks
    logic [11:0] adc_val[2];
    logic [11:0] cap[2];
    int falls[2], rises[2], tot_rises[2], overlap[2], minp[2], maxp[2], lastr[2];
    bit cv_prev[2], sk_prev[2];

    // done/accept history of engine 0
    int          done_t[$];
    logic [2:0]  done_ch[$];
    logic [11:0] done_dat[$];
    logic [2:0]  acc[$];

    // reference model: previous accepted channel and stale flag per engine
    logic [2:0] mprev[2];
    bit         mstale[2];

    ltc2308_conv_engine u_dut0 (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_i      (start[0]),
        .ch_i         (ch[0]),
`ifdef LTC2308_DIFF_MODE_EN
        .cfg_i        (cfg[0]),
`endif
        .busy_o       (busy[0]),
        .done_o       (done[0]),
        .data_o       (data[0]),
        .data_ch_o    (dch[0]),
        .data_stale_o (stale[0]),
        .ADC_CONVST_o (convst[0]),
        .ADC_SCK_o    (sck[0]),
        .ADC_SDI_o    (sdi[0]),
        .ADC_SDO_i    (sdo[0])
    );

    ltc2308_conv_engine #(
        .TCONV_CYCLES (T1C),
        .TACQ_CYCLES  (T1A),
        .SCK_HALF     (H1)
    ) u_dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_i      (start[1]),
        .ch_i         (ch[1]),
`ifdef LTC2308_DIFF_MODE_EN
        .cfg_i        (cfg[1]),
`endif
        .busy_o       (busy[1]),
        .done_o       (done[1]),
        .data_o       (data[1]),
        .data_ch_o    (dch[1]),
        .data_stale_o (stale[1]),
        .ADC_CONVST_o (convst[1]),
        .ADC_SCK_o    (sck[1]),
        .ADC_SDI_o    (sdi[1]),
        .ADC_SDO_i    (sdo[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_adc
        always @(negedge clock) begin
            if (convst[g] && !cv_prev[g]) begin
                falls[g] = 0; rises[g] = 0; cap[g] = '0; overlap[g] = 0;
                minp[g] = 1000; maxp[g] = 0;
            end
            if (sck[g] && !sk_prev[g]) begin
                if (rises[g] > 0) begin
                    if (cyc - lastr[g] < minp[g]) minp[g] = cyc - lastr[g];
                    if (cyc - lastr[g] > maxp[g]) maxp[g] = cyc - lastr[g];
                end
                rises[g]++;
                tot_rises[g]++;
                lastr[g] = cyc;
                cap[g] = {cap[g][10:0], sdi[g]};
            end
            if (!sck[g] && sk_prev[g]) falls[g]++;
            if (sck[g] && convst[g]) overlap[g]++;
            cv_prev[g] = convst[g];
            sk_prev[g] = sck[g];
            sdo[g] = (falls[g] < 12) ? adc_val[g][11 - falls[g]] : 1'b0;
        end
    end

    always @(negedge clock) begin
        if (done[0] === 1'b1) begin
            done_t.push_back(cyc);
            done_ch.push_back(dch[0]);
            done_dat.push_back(data[0]);
        end
    end

    always @(posedge clock) begin
        if (start[0] === 1'b1 && busy[0] === 1'b0) acc.push_back(ch[0]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] cfg_word(input logic [2:0] c, input logic [1:0] cf);
        // single-ended/unipolar when cf = 0; cf = {diff, bipolar}
        return {~cf[1], c[0], c[2], c[1], ~cf[0], 1'b0};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mprev[k]  = 3'd0;
            mstale[k] = 1'b1;
        end
    endtask

    task automatic chk_reset_vals(input string tag, input int k);
        chk(tag, {busy[k], done[k], data[k], dch[k], stale[k], convst[k], sck[k], sdi[k]},
                 {1'b0, 1'b0, 12'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    // one complete frame, start issued at the current negedge
    task automatic frame(input int k, input logic [2:0] c, input logic [11:0] v,
                         input logic [1:0] cf);
        int  t0;
        bit  seen;
        adc_val[k] = v;
`ifdef LTC2308_DIFF_MODE_EN
        cfg[k] = cf;
`endif
        ch[k]    = c;
        start[k] = 1'b1;
        t0       = cyc;
        @(negedge clock);
        start[k] = 1'b0;
        ch[k]    = 3'($urandom_range(0, 7));
        chk("busy_after_accept", 32'(busy[k]), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done[k] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc - t0), 32'(LAT[k]));
        chk("busy_in_done", 32'(busy[k]), 32'd1);
        chk("data", 32'(data[k]), 32'(v));
        chk("data_ch", 32'(dch[k]), 32'(mprev[k]));
        chk("stale", 32'(stale[k]), 32'(mstale[k]));
        chk("sdi_word", 32'(cap[k]), 32'({cfg_word(c, cf), 6'b000000}));
        chk("sck_pulses", 32'(rises[k]), 32'd12);
        chk("convst_during_sck", 32'(overlap[k]), 32'd0);
        chk("sck_period_min", 32'(minp[k]), 32'(2 * HALF[k]));
        chk("sck_period_max", 32'(maxp[k]), 32'(2 * HALF[k]));
        mprev[k]  = c;
        mstale[k] = 1'b0;
        @(negedge clock);
        chk("busy_after_done", 32'(busy[k]), 32'd0);
        chk("done_one_cycle", 32'(done[k]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0, r0;
        logic [11:0] bv;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            ch[k] = 3'd0;
            adc_val[k] = 12'h000;
`ifdef LTC2308_DIFF_MODE_EN
            cfg[k] = 2'b00;
`endif
        end
        model_reset();
        repeat (3) @(negedge clock);
        chk_reset_vals("reset_state0", 0);
        chk_reset_vals("reset_state1", 1);
        reset_n = 1'b1;
        @(negedge clock);

        // first frame after reset is stale
        frame(0, 3'd5, 12'($urandom), 2'b00);
        // fixed ADC value over two frames
        frame(0, 3'd3, 12'hA5C, 2'b00);
        frame(0, 3'd6, 12'hA5C, 2'b00);

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clock);
            frame(0, 3'($urandom_range(0, 7)), 12'($urandom), 2'b00);
        end

        // start held high every cycle with a changing channel
        bv = 12'($urandom);
        adc_val[0] = bv;
        a0 = acc.size();
        d0 = done_t.size();
        r0 = tot_rises[0];
        for (int i = 0; i < 400; i++) begin
            start[0] = 1'b1;
            ch[0] = 3'($urandom_range(0, 7));
            @(negedge clock);
        end
        start[0] = 1'b0;
        for (int i = 0; i < 120 && busy[0] !== 1'b0; i++) @(negedge clock);
        chk("burst_drained", 32'(busy[0]), 32'd0);
        chk("burst_accepts", 32'(acc.size() - a0), 32'd4);
        chk("burst_frames", 32'(done_t.size() - d0), 32'd4);
        chk("burst_sck_pulses", 32'(tot_rises[0] - r0), 32'd48);
        if (acc.size() - a0 == 4 && done_t.size() - d0 == 4) begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0) chk("burst_spacing", 32'(done_t[d0 + i] - done_t[d0 + i - 1]), 32'd100);
                chk("burst_data_ch", 32'(done_ch[d0 + i]), 32'((i == 0) ? mprev[0] : acc[a0 + i - 1]));
                chk("burst_data", 32'(done_dat[d0 + i]), 32'(bv));
            end
            mprev[0] = acc[a0 + 3];
        end
        @(negedge clock);

        // reset in the middle of SHIFT, during bit 7
        adc_val[0] = 12'($urandom);
        ch[0] = 3'd4;
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        for (int i = 0; i < 200 && rises[0] != 7; i++) @(negedge clock);
        chk("reached_bit7", 32'(rises[0]), 32'd7);
        d0 = done_t.size();
        reset_n = 1'b0;
        #1;
        chk_reset_vals("abort_reset_vals", 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clock);
        chk("abort_no_done", 32'(done_t.size() - d0), 32'd0);
        chk("abort_idle", 32'(busy[0]), 32'd0);
        frame(0, 3'd7, 12'($urandom), 2'b00);
        frame(0, 3'd1, 12'($urandom), 2'b00);

        // slow SCK engine
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            frame(1, 3'($urandom_range(0, 7)), 12'($urandom), 2'b00);
        end

`ifdef LTC2308_DIFF_MODE_EN
        frame(0, 3'd2, 12'($urandom), 2'b11);
        chk("diff_word", 32'(cap[0][11:6]), 32'(6'b000100));
        frame(1, 3'd5, 12'($urandom), 2'b10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
